// File: rtl/cmp_sweep_checker.sv
// Built-in self-test that sweeps every {a,b} pair into a magnitude comparator and checks greater/less.
// Optional macro CMP_CHK_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module cmp_sweep_checker #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 1,
   parameter int ERRW   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   input  logic             greater,
   input  logic             less,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERRW-1:0]  err_count,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic            mismatch;
   logic            last_vec;
   logic [ERRW-1:0] err_next;

   always_comb begin
      mismatch = (greater != (a > b)) || (less != (a < b));
      last_vec = &{a, b};
      err_next = (&err_count) ? err_count : err_count + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         a           <= '0;
         b           <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= '0;
         first_err_a <= '0;
         first_err_b <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  {a, b}      <= '0;
                  err_count   <= '0;
                  first_err_a <= '0;
                  first_err_b <= '0;
                  pass        <= 1'b0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  wait_cnt    <= '0;
                  state       <= (SETTLE == 0) ? S_CHECK : S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  wait_cnt <= '0;
                  state    <= S_CHECK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               // err_count never returns to zero mid-sweep, so zero marks "no error yet"
               if (mismatch && err_count == '0) begin
                  first_err_a <= a;
                  first_err_b <= b;
               end
`ifdef CMP_CHK_STOP_ON_ERR_EN
               if (mismatch) begin
                  err_count <= ERRW'(1);
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  state     <= S_DONE;
               end else
`endif
               begin
                  if (mismatch) err_count <= err_next;
                  if (last_vec) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == '0) && !mismatch;
                     state <= S_DONE;
                  end else begin
                     {a, b} <= {a, b} + 1'b1;
                     state  <= (SETTLE == 0) ? S_CHECK : S_WAIT;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Bench for cmp_sweep_checker: a 2-bit/SETTLE=1 instance against faulty comparator models and an 8-bit/SETTLE=0 instance.
module tb_cmp_sweep_checker;

   logic clk = 1'b0;
   logic reset, start, start8;
   always #5 clk = ~clk;

   // small instance
   logic [1:0] a, b, fea, feb;
   logic       greater, less, busy, done, pass;
   logic [3:0] err_count;

   // full-width instance
   logic [7:0] a8, b8, fea8, feb8;
   logic       greater8, less8, busy8, done8, pass8;
   logic [15:0] err8;

   int          mode;
   logic [15:0] flip_g, flip_l;
   int          n_checks = 0;
   int          n_fail   = 0;

   cmp_sweep_checker #(.WIDTH(2), .SETTLE(1), .ERRW(4)) u_dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .greater(greater), .less(less), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_a(fea), .first_err_b(feb));

   cmp_sweep_checker #(.WIDTH(8), .SETTLE(0), .ERRW(16)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
      .greater(greater8), .less(less8), .busy(busy8), .done(done8), .pass(pass8),
      .err_count(err8), .first_err_a(fea8), .first_err_b(feb8));

   // Comparator under test: 0 correct, 1 greater stuck 0, 2 outputs swapped, 3 per-vector bit flips
   function automatic logic [1:0] cmp_model(int md, int av, int bv, logic [15:0] fg, logic [15:0] fl);
      logic g, l;
      g = av > bv;
      l = av < bv;
      case (md)
         1: g = 1'b0;
         2: begin g = av < bv; l = av > bv; end
         3: begin g = g ^ fg[av*4+bv]; l = l ^ fl[av*4+bv]; end
         default: ;
      endcase
      return {g, l};
   endfunction

   always_comb {greater, less} = cmp_model(mode, int'(a), int'(b), flip_g, flip_l);
   always_comb begin
      greater8 = a8 > b8;
      less8    = a8 < b8;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: walk the 16 vectors in sweep order and apply the checker's rules directly
   task automatic ref_sweep(output int e_err, output int e_fa, output int e_fb, output int e_pass,
                            output int e_cyc, output int e_la, output int e_lb);
      int cnt, last;
      logic [1:0] o;
      cnt = 0; e_fa = 0; e_fb = 0; last = 15;
      for (int n = 0; n < 16; n++) begin
         int av, bv;
         av = n >> 2;
         bv = n & 3;
         o = cmp_model(mode, av, bv, flip_g, flip_l);
         if (o[1] != (av > bv) || o[0] != (av < bv)) begin
            if (cnt == 0) begin e_fa = av; e_fb = bv; end
            cnt++;
`ifdef CMP_CHK_STOP_ON_ERR_EN
            last = n;
            break;
`endif
         end
      end
      e_err  = (cnt > 15) ? 15 : cnt;
      e_pass = (cnt == 0);
      e_cyc  = (last + 1) * 2;
      e_la   = last >> 2;
      e_lb   = last & 3;
   endtask

   task automatic run_sweep(input string tag, input bit poke);
      int cyc, e_err, e_fa, e_fb, e_pass, e_cyc, e_la, e_lb;
      ref_sweep(e_err, e_fa, e_fb, e_pass, e_cyc, e_la, e_lb);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      chk({tag, "_busy_start"}, {busy, done, err_count}, {1'b1, 1'b0, 4'd0});
      while (!done && cyc < 200) begin
         start = poke && (cyc == 5);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, "_cycles"}, cyc, e_cyc);
      chk({tag, "_err"}, err_count, e_err);
      chk({tag, "_first"}, {fea, feb}, {e_fa[1:0], e_fb[1:0]});
      chk({tag, "_pass"}, {busy, done, pass}, {1'b0, 1'b1, e_pass[0]});
      chk({tag, "_last_ab"}, {a, b}, {e_la[1:0], e_lb[1:0]});
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; start8 = 1'b0; mode = 0;
      flip_g = '0; flip_l = '0;
      repeat (3) @(negedge clk);
      chk("reset_small", {a, b, busy, done, pass, err_count, fea, feb}, 32'd0);
      chk("reset_wide", {a8, b8, busy8, done8, pass8, fea8, feb8}, 32'd0);
      chk("reset_wide_err", err8, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      mode = 0; run_sweep("correct", 1'b1);
      mode = 1; run_sweep("g_stuck0", 1'b0);
      mode = 2; run_sweep("swapped", 1'b1);
      // restart from DONE must clear the previous result
      mode = 0; run_sweep("correct_again", 1'b0);
      mode = 3;
      for (int r = 0; r < 4; r++) begin
         flip_g = 16'($urandom & $urandom & $urandom);
         flip_l = 16'($urandom & $urandom & $urandom);
         run_sweep($sformatf("rand%0d", r), r[0]);
      end
      flip_g = 16'hFFFF; flip_l = 16'h0000;
      run_sweep("saturate", 1'b0);

      // asynchronous abort mid-sweep
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_abort_busy", busy, 1'b1);
      #1 reset = 1'b1;
      #1 chk("abort_clear", {a, b, busy, done, pass, err_count, fea, feb}, 32'd0);
      @(negedge clk) reset = 1'b0;
      mode = 0; run_sweep("after_abort", 1'b1);

      // 8-bit sweep, SETTLE=0: one vector per cycle
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
      cyc = 0;
      while (!done8 && cyc < 70000) begin
         @(negedge clk);
         cyc++;
      end
      chk("w8_cycles", cyc, 65536);
      chk("w8_result", {busy8, done8, pass8, a8, b8}, {1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF});
      chk("w8_err", {err8, fea8, feb8}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cmp_sweep_checker.md
Name: cmp_sweep_checker

Overview:
- Synthesizable hardware counterpart of the comparator sweep bench: drives every {a,b} combination into a magnitude comparator (compare / cmp4 / cmp8 family), samples its greater/less outputs and checks them against a golden a>b / a<b result.
- Sits beside the DUT on the FPGA as a built-in self-test. Reports pass/fail, error count and the first failing vector.

Parameters:
- WIDTH, 8, operand width of a and b; number of vectors is 2^(2*WIDTH).
- SETTLE, 1, wait cycles between driving a vector and sampling the DUT outputs (0 allowed).
- ERRW, 16, width of the error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a sweep.
- a  out  WIDTH  operand A to DUT, registered.
- b  out  WIDTH  operand B to DUT, registered.
- greater  in  1  DUT output: a>b.
- less  in  1  DUT output: a<b.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start or reset.
- pass  out  1  valid when done=1; 1 if err_count==0.
- err_count  out  ERRW  mismatching vectors, saturating.
- first_err_a  out  WIDTH  a of the first mismatch; 0 if none.
- first_err_b  out  WIDTH  b of the first mismatch; 0 if none.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: all outputs 0; state=IDLE.
- Vector register: {a,b} is a single 2*WIDTH counter, with a as the MSBs. This matches the bench ordering: vector n has a=n>>WIDTH and b=n mod 2^WIDTH.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE: on start=1, do {a,b}<=0, clear err_count, first_err_*, pass and done; set busy<=1. Go to WAIT, or directly to CHECK if SETTLE==0.
- WAIT: count SETTLE cycles, then go to CHECK.
- CHECK: sample greater/less against exp_g=(a>b) and exp_l=(a<b), unsigned. A mismatch on either bit is one error:
  - err_count increments and saturates at all-ones.
  - On the first error, latch a/b into first_err_a/b.
- CHECK, not last vector: {a,b}<={a,b}+1, then go to WAIT (or stay in CHECK if SETTLE==0).
- CHECK, last vector ({a,b} all ones): the counter does not wrap. Go to DONE with busy<=0, done<=1, and pass<=(err_count==0 including this vector).
- DONE: a and b hold their last value. start=1 restarts exactly as from IDLE.
- Per-vector period: SETTLE+1 cycles. Total sweep: 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to done rising.
- Simultaneous events: start while busy is ignored. reset mid-sweep aborts immediately to reset values.
- Equality case: DUT is expected to output greater=0 and less=0. greater=less=1 is always an error.

Optional Feature:
- Macro: CMP_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes straight to DONE with pass=0 and err_count=1. a/b freeze at the failing vector.
- Undefined: the sweep always runs to completion and counts all errors.

Test Plan:
- WIDTH=2, SETTLE=1, correct DUT, start pulse -> done rises exactly 32 cycles after the start edge; pass=1, err_count=0, first_err_a/b=0.
- WIDTH=2, greater forced to 0 -> 6 vectors with a>b fail; err_count=6, pass=0, first_err_a=1, first_err_b=0.
- WIDTH=2, less and greater swapped -> 12 errors, first_err=(0,1); equal vectors do not count.
- WIDTH=8, SETTLE=0, correct cmp8 -> 65536 cycles, pass=1, and a=b=8'hFF at done.
- Reset asserted at cycle 10 of a sweep -> all outputs 0 the same cycle; a new start gives a clean full sweep. start pulsed while busy -> no effect on timing.
- With CMP_CHK_STOP_ON_ERR_EN, greater stuck at 0 -> done at vector {a,b}=4'b0100, err_count=1, a=1, b=0.
